weight_write: RTL and testbench

Upstream producer for the weight-read stage: accepts a 256-bit weight stream from the DMA, distributes it round-robin across the eight weight BRAM banks, and fills them in ping-pong halves (base 0 / base 512). A half is refilled only after the read stage releases it. Per-layer load sizes are set at start.

---
 rtl/weight_write_pkg.sv | 60 ++++++
 rtl/weight_write_if.sv | 37 +++
 rtl/weight_write_pingpong_tracker.sv | 64 ++++++
 rtl/weight_write.sv | 156 +++++++++++++++
 tb/tb_weight_write.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/weight_write_pkg.sv
// Shared definitions for the weight BRAM write path and its read-stage partner.
// Holds the layer ids, the per-layer fill geometry (DEPTH words per bank per
// half, LOADS halves per layer), the ping-pong base address, the bank count,
// and the write FSM state encoding.
package weight_write_pkg;

    localparam int NUM_BANKS = 8;
    localparam int HALF_BASE = 512;

    // Layer ids as carried on the layer input.
    localparam logic [2:0] LAYER_1 = 3'd1;
    localparam logic [2:0] LAYER_2 = 3'd2;
    localparam logic [2:0] LAYER_3 = 3'd3;
    localparam logic [2:0] LAYER_4 = 3'd4;

    // Fill geometry per layer. The read stage walks the same geometry, so
    // these values must stay in lock-step with it.
    localparam int L1_DEPTH = 16;
    localparam int L1_LOADS = 4;
    localparam int L2_DEPTH = 512;
    localparam int L2_LOADS = 72;
    localparam int L3_DEPTH = 512;
    localparam int L3_LOADS = 16;
    localparam int L4_DEPTH = 512;
    localparam int L4_LOADS = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CONFIG    = 2'd1,
        LOAD      = 2'd2,
        WAIT_FREE = 2'd3
    } wr_state_t;

    typedef struct packed {
        logic [9:0] depth;   // words per bank per half, up to 512
        logic [6:0] loads;   // halves per layer, up to 72; 0 = nothing to load
    } layer_cfg_t;

    // Geometry lookup; unknown ids come back with loads = 0.
    function automatic layer_cfg_t layer_cfg(input logic [2:0] id);
        layer_cfg_t c;
        c.depth = '0;
        c.loads = '0;
        case (id)
            LAYER_1: begin c.depth = 10'(L1_DEPTH); c.loads = 7'(L1_LOADS); end
            LAYER_2: begin c.depth = 10'(L2_DEPTH); c.loads = 7'(L2_LOADS); end
            LAYER_3: begin c.depth = 10'(L3_DEPTH); c.loads = 7'(L3_LOADS); end
            LAYER_4: begin c.depth = 10'(L4_DEPTH); c.loads = 7'(L4_LOADS); end
            default: ;
        endcase
        return c;
    endfunction

    // Index of the final beat of a half: 8 banks * depth words, minus one.
    // A 512-deep half gives 4095, which is why the beat counter is 12 bits.
    function automatic logic [11:0] last_beat(input logic [9:0] depth);
        return 12'({depth, 3'b000} - 13'd1);
    endfunction

endpackage

// File: rtl/weight_write_if.sv
// Stream-in / BRAM-write bundle of the weight write stage.
// master: the side that produces the stream and consumes the bank writes.
// slave : the weight_write block itself.
//   s_valid/s_data/s_ready : 256-bit weight beats from the DMA
//   en_wr/addr_wr/dout     : one-hot bank enable, shared address and data
interface weight_write_if #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 12
);
    import weight_write_pkg::*;

    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_ready;
    logic [NUM_BANKS-1:0]  en_wr;
    logic [ADDR_WIDTH-1:0] addr_wr;
    logic [DATA_WIDTH-1:0] dout;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready,
        input  en_wr,
        input  addr_wr,
        input  dout
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready,
        output en_wr,
        output addr_wr,
        output dout
    );

endinterface

// File: rtl/weight_write_pingpong_tracker.sv
// Ping-pong occupancy of the two weight BRAM halves (full flags, read/write pointers).
// Latency: flags and pointers update on the clock edge after a fill or release pulse.
// Backpressure: none itself; wr_free/nxt_free tell the writer whether it may proceed.
//   clk, rst  : clock, synchronous active-high reset
//   rel       : read stage has consumed the oldest full half
//   fill      : writer has just completed the half at wr_ptr
//   wr_ptr    : half currently targeted by the writer
//   wr_free   : half at wr_ptr is free, counting a release in this same cycle
//   nxt_free  : the other half is free, counting a release in this same cycle
module pingpong_tracker (
    input  logic clk,
    input  logic rst,
    input  logic rel,
    input  logic fill,
    output logic wr_ptr,
    output logic wr_free,
    output logic nxt_free
);

    logic [1:0] full_q;
    logic [1:0] full_d;
    logic       rd_ptr_q;
    logic       wr_ptr_q;
    logic       rel_eff;

    // Halves fill and drain in order, so if any half is full the one at
    // rd_ptr is; a release with nothing full is simply dropped.
    assign rel_eff = rel && full_q[rd_ptr_q];

    // A fill and a release may land together; they always hit different
    // halves because the writer never targets a half that is still full.
    always_comb begin
        full_d = full_q;
        if (rel_eff) begin
            full_d[rd_ptr_q] = 1'b0;
        end
        if (fill) begin
            full_d[wr_ptr_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q   <= 2'b00;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            full_q <= full_d;
            if (rel_eff) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            if (fill) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
        end
    end

    // Looking through a same-cycle release lets the writer carry straight on
    // (or resume) on the next cycle instead of waiting for the flag to settle.
    assign wr_ptr   = wr_ptr_q;
    assign wr_free  = !full_q[wr_ptr_q] || (rel_eff && (rd_ptr_q == wr_ptr_q));
    assign nxt_free = !full_q[!wr_ptr_q] || (rel_eff && (rd_ptr_q != wr_ptr_q));

endmodule

// File: rtl/weight_write.sv
// Weight stream to BRAM writer: round-robin over 8 banks, ping-pong halves per layer.
// Latency: en_wr/addr_wr/dout registered, 1 cycle after the accepting handshake.
// Backpressure: s_ready drops while the half to be written is still held by the reader.
//   clk, rst      : clock, synchronous active-high reset
//   start, layer  : begin a layer (sampled only while idle) and its id
//   half_release  : read stage has consumed the oldest full half
//   bus (slave)   : s_valid/s_data/s_ready stream in, en_wr/addr_wr/dout bank writes out
//   half_done     : pulse with the write of the last beat of a half
//   write_done    : pulse when the whole layer is written (or has nothing to write)
module weight_write #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 12,
    parameter int HALF_BASE  = weight_write_pkg::HALF_BASE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2:0]           layer,
    input  logic                 half_release,
    weight_write_if.slave        bus,
    output logic                 half_done,
    output logic                 write_done
);

    import weight_write_pkg::*;

    wr_state_t             state_q;
    logic [2:0]            layer_q;
    logic [11:0]           last_beat_q;
    logic [6:0]            loads_q;
    logic [11:0]           beat_q;
    logic [6:0]            load_cnt_q;
    logic                  s_ready_q;
    logic [NUM_BANKS-1:0]  en_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  half_done_q;
    logic                  write_done_q;

    logic                  hs;
    logic                  fill;
    logic                  wr_ptr;
    logic                  wr_free;
    logic                  nxt_free;
    logic                  last_load;
    layer_cfg_t            cfg;
    logic [ADDR_WIDTH-1:0] base_addr;

    // s_ready_q is only ever set in LOAD, so a handshake implies LOAD.
    assign hs        = bus.s_valid && s_ready_q;
    assign fill      = hs && (beat_q == last_beat_q);
    assign last_load = (7'(load_cnt_q + 7'd1) == loads_q);
    assign base_addr = wr_ptr ? ADDR_WIDTH'(HALF_BASE) : '0;

    always_comb begin
        cfg = layer_cfg(layer_q);
    end

    pingpong_tracker u_tracker (
        .clk      (clk),
        .rst      (rst),
        .rel      (half_release),
        .fill     (fill),
        .wr_ptr   (wr_ptr),
        .wr_free  (wr_free),
        .nxt_free (nxt_free)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            layer_q      <= '0;
            last_beat_q  <= '0;
            loads_q      <= '0;
            beat_q       <= '0;
            load_cnt_q   <= '0;
            s_ready_q    <= 1'b0;
            en_q         <= '0;
            addr_q       <= '0;
            dout_q       <= '0;
            half_done_q  <= 1'b0;
            write_done_q <= 1'b0;
        end else begin
            en_q         <= '0;
            half_done_q  <= 1'b0;
            write_done_q <= 1'b0;

            // Beat k of a half lands in bank k mod 8 at base + k/8.
            if (hs) begin
                en_q[beat_q[2:0]] <= 1'b1;
                addr_q            <= base_addr + ADDR_WIDTH'(beat_q[11:3]);
                dout_q            <= bus.s_data;
                beat_q            <= fill ? 12'd0 : 12'(beat_q + 12'd1);
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        layer_q <= layer;
                        state_q <= CONFIG;
                    end
                end

                CONFIG: begin
                    last_beat_q <= last_beat(cfg.depth);
                    loads_q     <= cfg.loads;
                    load_cnt_q  <= '0;
                    beat_q      <= '0;
                    if (cfg.loads == 7'd0) begin
                        write_done_q <= 1'b1;
                        state_q      <= IDLE;
                    end else if (wr_free) begin
                        s_ready_q <= 1'b1;
                        state_q   <= LOAD;
                    end else begin
                        state_q <= WAIT_FREE;
                    end
                end

                LOAD: begin
                    if (fill) begin
                        half_done_q <= 1'b1;
                        load_cnt_q  <= 7'(load_cnt_q + 7'd1);
                        if (last_load) begin
                            // Dropping s_ready here guarantees no beat past
                            // the layer's total is ever accepted.
                            write_done_q <= 1'b1;
                            s_ready_q    <= 1'b0;
                            state_q      <= IDLE;
                        end else if (!nxt_free) begin
                            s_ready_q <= 1'b0;
                            state_q   <= WAIT_FREE;
                        end
                    end
                end

                WAIT_FREE: begin
                    if (wr_free) begin
                        s_ready_q <= 1'b1;
                        state_q   <= LOAD;
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.s_ready = s_ready_q;
    assign bus.en_wr   = en_q;
    assign bus.addr_wr = addr_q;
    assign bus.dout    = dout_q;
    assign half_done   = half_done_q;
    assign write_done  = write_done_q;

endmodule

// File: tb/tb_weight_write.sv
// Randomized bench for weight_write against a behavioural model of the layer fill.
// The model tracks accepted beats of the layer and how many halves are occupied,
// and derives bank/address/data, half_done, write_done and s_ready from those.
module tb_weight_write;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  layer = 3'd0;
    logic        half_release = 1'b0;
    logic        half_done;
    logic        write_done;

    always #5 clk = ~clk;

    weight_write_if #(.DATA_WIDTH(256), .ADDR_WIDTH(12)) bus ();

    weight_write #(.DATA_WIDTH(256), .ADDR_WIDTH(12), .HALF_BASE(512)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .layer        (layer),
        .half_release (half_release),
        .bus          (bus.slave),
        .half_done    (half_done),
        .write_done   (write_done)
    );

    int checks = 0;
    int errors = 0;

    // Model state
    int mphase = 0;   // 0 idle, 1 configuring, 2 loading/waiting
    int occ    = 0;   // halves full and not yet released
    int parity = 0;   // which half the next fill goes to
    int n_acc  = 0;   // beats accepted in this layer
    int hb     = 0;   // beats per half
    int total  = 0;   // beats per layer
    int wr_obs = 0;   // observed en_wr pulses

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic layer_geom(input logic [2:0] id, output int depth, output int loads);
        case (id)
            3'd1: begin depth = 16;  loads = 4;  end
            3'd2: begin depth = 512; loads = 72; end
            3'd3: begin depth = 512; loads = 16; end
            3'd4: begin depth = 512; loads = 4;  end
            default: begin depth = 0; loads = 0; end
        endcase
    endtask

    // One clock: check s_ready, predict the edge, then check the registered outputs.
    task automatic step();
        logic         exp_rdy, hs, fill, rel_eff, was_rst;
        logic [7:0]   e_en;
        logic [11:0]  e_addr;
        logic [255:0] e_dat;
        logic         e_hd, e_wd;
        int           ph, k, d, l;
        exp_rdy = (mphase == 2) && (occ < 2);
        check("s_ready", bus.s_ready, exp_rdy);
        e_en = '0; e_addr = '0; e_dat = '0; e_hd = 1'b0; e_wd = 1'b0;
        was_rst = rst;
        if (rst) begin
            mphase = 0; occ = 0; parity = 0; n_acc = 0;
        end else begin
            ph      = mphase;
            rel_eff = half_release && (occ > 0);
            hs      = bus.s_valid && exp_rdy;
            fill    = 1'b0;
            if (hs) begin
                k      = n_acc % hb;
                e_en   = 8'd1 << (k % 8);
                e_addr = 12'(parity * 512 + k / 8);
                e_dat  = bus.s_data;
                n_acc++;
                if (k == hb - 1) begin fill = 1'b1; e_hd = 1'b1; end
                if (n_acc == total) begin e_wd = 1'b1; mphase = 0; end
            end
            occ = occ + (fill ? 1 : 0) - (rel_eff ? 1 : 0);
            if (fill) parity = 1 - parity;
            if (ph == 0 && start) begin
                layer_geom(layer, d, l);
                hb = 8 * d; total = hb * l; n_acc = 0; mphase = 1;
            end else if (ph == 1) begin
                if (total == 0) begin e_wd = 1'b1; mphase = 0; end
                else mphase = 2;
            end
        end
        @(posedge clk);
        #1;
        check("en_wr", bus.en_wr, e_en);
        if (e_en != 0 || was_rst) begin
            check("addr_wr", bus.addr_wr, e_addr);
            check("dout", bus.dout, e_dat);
        end
        check("half_done", half_done, e_hd);
        check("write_done", write_done, e_wd);
        if (bus.en_wr != 0) wr_obs++;
    endtask

    task automatic cyc(input logic v, input logic rel, input logic st);
        bus.s_valid  = v;
        bus.s_data   = {$urandom, $urandom, $urandom, $urandom,
                        $urandom, $urandom, $urandom, $urandom};
        half_release = rel;
        start        = st;
        step();
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && occ > 0; i++) begin
            cyc(1'b0, 1'b1, 1'b0);
            repeat (3) cyc(1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        int  stall;
        int  rels;
        logic rel;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        cyc(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        check("rst_s_ready", bus.s_ready, 1'b0);
        check("rst_en_wr", bus.en_wr, 8'd0);
        check("rst_addr", bus.addr_wr, 12'd0);
        check("rst_half_done", half_done, 1'b0);

        // Spurious release in IDLE
        cyc(1'b0, 1'b1, 1'b0);
        repeat (2) cyc(1'b0, 1'b0, 1'b0);

        // Layer 1, continuous stream, late releases, one coincident with a last beat
        layer = 3'd1;
        cyc(1'b0, 1'b0, 1'b1);
        wr_obs = 0; stall = 0; rels = 0;
        for (int c = 0; c < 3000; c++) begin
            rel = 1'b0;
            if (mphase == 2 && occ == 2) stall++;
            if (rels == 0 && stall == 20) rel = 1'b1;
            if (rels == 1 && n_acc == 383 && bus.s_ready) rel = 1'b1;
            if (rel) rels++;
            cyc(1'b1, rel, 1'b0);
            if (rel && rels == 2) check("coincident_no_stall", bus.s_ready, 1'b1);
            if (write_done) break;
        end
        check("l1_complete", write_done, 1'b1);
        check("l1_beats", wr_obs, 512);
        repeat (5) cyc(1'b0, 1'b0, 1'b0);
        drain();
        cyc(1'b0, 1'b1, 1'b0);

        // Layer 1, random valid and random releases
        layer = 3'd1;
        cyc(1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 6000; c++) begin
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0, 1'b0);
            if (write_done) break;
        end
        check("rnd_complete", write_done, 1'b1);
        drain();

        // Invalid layer id
        layer = 3'd6;
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        check("inv_write_done", write_done, 1'b1);
        check("inv_en_wr", bus.en_wr, 8'd0);
        check("inv_s_ready", bus.s_ready, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        check("inv_wd_pulse", write_done, 1'b0);

        // Layer 3 with no release: two halves then stall
        layer = 3'd3;
        cyc(1'b0, 1'b0, 1'b1);
        wr_obs = 0;
        for (int c = 0; c < 9000 && wr_obs < 8192; c++) cyc(1'b1, 1'b0, 1'b0);
        repeat (40) cyc(1'b1, 1'b0, 1'b0);
        check("bp_accepted", wr_obs, 8192);
        check("bp_ready_low", bus.s_ready, 1'b0);
        cyc(1'b1, 1'b1, 1'b0);
        check("bp_resume", bus.s_ready, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        check("bp_bank0", bus.en_wr, 8'd1);
        check("bp_addr0", bus.addr_wr, 12'd0);
        for (int c = 0; c < 200 && n_acc < 8192 + 100; c++) cyc(1'b1, 1'b0, 1'b0);

        // Mid-load reset
        rst = 1'b1;
        cyc(1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        check("mrst_en_wr", bus.en_wr, 8'd0);
        check("mrst_s_ready", bus.s_ready, 1'b0);
        check("mrst_dout", bus.dout, 256'd0);

        // Restart after reset
        layer = 3'd1;
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        check("restart_bank0", bus.en_wr, 8'd1);
        check("restart_addr0", bus.addr_wr, 12'd0);
        for (int c = 0; c < 6000; c++) begin
            cyc($urandom_range(0, 4) != 0, $urandom_range(0, 24) == 0, 1'b0);
            if (write_done) break;
        end
        check("restart_complete", write_done, 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
